// File: rtl/lcd_bus_reader_if.sv
// Read-side handshake and LCD pin bundle for lcd_bus_reader.
// master: requester / pad side; slave: the reader engine.
interface lcd_bus_reader_if;
    logic       rd_req;
    logic       rd_rs;
    logic       rd_poll;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_timeout;
    logic [7:0] lcd_din;
    logic       bus_rel;
    logic       RS;
    logic       RW;
    logic       EN;

    modport master (
        output rd_req, rd_rs, rd_poll, lcd_din,
        input  rd_ready, rd_valid, rd_data, rd_timeout, bus_rel, RS, RW, EN
    );

    modport slave (
        input  rd_req, rd_rs, rd_poll, lcd_din,
        output rd_ready, rd_valid, rd_data, rd_timeout, bus_rel, RS, RW, EN
    );
endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit bus read engine: one RW=1 cycle per request (busy flag /
// address when rd_rs=0, RAM data when rd_rs=1), sampled byte returned on rd_valid.
// Optional busy-flag polling is compiled in with `define LCD_BF_POLL_EN.
//
// state  | meaning
// IDLE   | rd_ready=1, waiting for rd_req
// SETUP  | RS/RW driven, EN low for address setup
// STROBE | EN high, data sampled on last high cycle
// HOLD   | EN low, RS/RW held
// GAP    | EN low between polled BF reads (LCD_BF_POLL_EN only)
// DONE   | rd_valid pulse, pins released
module lcd_bus_reader #(
    parameter int T_AS_CYC     = 3,
    parameter int T_PW_CYC     = 25,
    parameter int T_H_CYC      = 2,
    parameter int T_GAP_CYC    = 25,
    parameter int POLL_TIMEOUT = 500000
) (
    input  logic clk,
    input  logic rst_n,
    lcd_bus_reader_if.slave bus
);

    localparam int MAX_A = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
    localparam int MAX_B = (T_H_CYC > T_GAP_CYC) ? T_H_CYC : T_GAP_CYC;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] AS_LD = CW'(T_AS_CYC - 1);
    localparam logic [CW-1:0] PW_LD = CW'(T_PW_CYC - 1);
    localparam logic [CW-1:0] H_LD  = CW'(T_H_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
`ifdef LCD_BF_POLL_EN
        GAP,
`endif
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ready_q;
    logic          valid_q;
    logic [7:0]    data_q;
    logic          rel_q;
    logic          rs_q;
    logic          rw_q;
    logic          en_q;

`ifdef LCD_BF_POLL_EN
    localparam int            PCW    = $clog2(POLL_TIMEOUT + 1);
    localparam logic [CW-1:0] GAP_LD = CW'(T_GAP_CYC - 1);
    localparam logic [PCW-1:0] PT    = PCW'(POLL_TIMEOUT);

    logic           poll_q;
    logic [PCW-1:0] poll_cnt;
    logic           timeout_q;

    assign bus.rd_timeout = timeout_q;
`else
    localparam int unused_poll_timeout = POLL_TIMEOUT;
    logic unused_poll;

    assign unused_poll    = bus.rd_poll;
    assign bus.rd_timeout = 1'b0;
`endif

    assign bus.rd_ready = ready_q;
    assign bus.rd_valid = valid_q;
    assign bus.rd_data  = data_q;
    assign bus.bus_rel  = rel_q;
    assign bus.RS       = rs_q;
    assign bus.RW       = rw_q;
    assign bus.EN       = en_q;

    // Read-cycle sequencer; every pin and handshake output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            rel_q     <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            en_q      <= 1'b0;
`ifdef LCD_BF_POLL_EN
            poll_q    <= 1'b0;
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_req) begin
                        rs_q    <= bus.rd_rs;
                        rw_q    <= 1'b1;
                        rel_q   <= 1'b1;
                        ready_q <= 1'b0;
                        cnt     <= AS_LD;
`ifdef LCD_BF_POLL_EN
                        // Polling only makes sense on the busy-flag register.
                        poll_q   <= bus.rd_poll & ~bus.rd_rs;
                        poll_cnt <= '0;
`endif
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        en_q  <= 1'b1;
                        cnt   <= PW_LD;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        en_q   <= 1'b0;
                        data_q <= bus.lcd_din;
                        cnt    <= H_LD;
`ifdef LCD_BF_POLL_EN
                        poll_cnt <= poll_cnt + 1'b1;
`endif
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
`ifdef LCD_BF_POLL_EN
                        if (poll_q && data_q[7] && (poll_cnt < PT)) begin
                            cnt   <= GAP_LD;
                            state <= GAP;
                        end else begin
                            valid_q   <= 1'b1;
                            timeout_q <= poll_q & data_q[7];
                            rs_q      <= 1'b0;
                            rw_q      <= 1'b0;
                            rel_q     <= 1'b0;
                            state     <= DONE;
                        end
`else
                        valid_q <= 1'b1;
                        rs_q    <= 1'b0;
                        rw_q    <= 1'b0;
                        rel_q   <= 1'b0;
                        state   <= DONE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef LCD_BF_POLL_EN
                GAP: begin
                    if (cnt == '0) begin
                        en_q  <= 1'b1;
                        cnt   <= PW_LD;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                DONE: begin
                    valid_q <= 1'b0;
`ifdef LCD_BF_POLL_EN
                    timeout_q <= 1'b0;
`endif
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: directed HD44780 read scenarios plus
// randomized reads, checked against a transaction-level model of the read cycle.
module tb_lcd_bus_reader;

    localparam int T_AS = 3;
    localparam int T_PW = 25;
    localparam int T_H  = 2;
    localparam int T_GP = 25;
    localparam int PT   = 4;
`ifdef LCD_BF_POLL_EN
    localparam bit POLL_BUILD = 1'b1;
`else
    localparam bit POLL_BUILD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] data_q[$];

    lcd_bus_reader_if bus ();

    lcd_bus_reader #(
        .T_AS_CYC    (T_AS),
        .T_PW_CYC    (T_PW),
        .T_H_CYC     (T_H),
        .T_GAP_CYC   (T_GP),
        .POLL_TIMEOUT(PT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One read transaction. The model predicts, from the byte sequence the LCD
    // presents, how many strobes happen, which byte is returned and the latency.
    task automatic run_read(input string tag, input logic rs, input logic poll, input bit busy_pulses);
        int exp_reads, exp_lat, cyc, pulses, hi_len, last_len, idx, viol, limit, w;
        logic [7:0] exp_data;
        logic exp_to, prev_en, seen;
        logic [7:0] got_data;
        logic got_to, got_rs, got_rw, got_rel, got_en;

        if (POLL_BUILD && poll && !rs) begin
            exp_reads = 0;
            exp_data  = 8'h00;
            for (int i = 0; i < data_q.size(); i++) begin
                exp_reads = i + 1;
                exp_data  = data_q[i];
                if (!data_q[i][7] || exp_reads == PT) break;
            end
            exp_to = exp_data[7];
        end else begin
            exp_reads = 1;
            exp_data  = data_q[0];
            exp_to    = 1'b0;
        end
        exp_lat = T_AS + exp_reads * (T_PW + T_H) + (exp_reads - 1) * T_GP + 1;
        limit   = exp_lat + 60;

        w = 0;
        @(negedge clk);
        while (bus.rd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk({tag, "_ready_wait"}, 32'd0, 32'd1);

        bus.rd_rs   = rs;
        bus.rd_poll = poll;
        bus.lcd_din = data_q[0];
        bus.rd_req  = 1'b1;
        @(posedge clk);
        #1 bus.rd_req = 1'b0;

        cyc = 0; pulses = 0; hi_len = 0; last_len = 0; idx = 0; viol = 0;
        prev_en = 1'b0; seen = 1'b0;
        got_data = 8'h00; got_to = 1'b0; got_rs = 1'b1; got_rw = 1'b1; got_rel = 1'b1; got_en = 1'b1;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            bus.rd_req = busy_pulses && (cyc == 5 || cyc == 20);
            if (bus.EN && !prev_en) begin
                pulses++;
                hi_len = 1;
            end else if (bus.EN) begin
                hi_len++;
            end
            if (!bus.EN && prev_en) begin
                last_len = hi_len;
                idx++;
                if (idx < data_q.size()) bus.lcd_din = data_q[idx];
            end
            if (bus.EN && bus.RW !== 1'b1) viol++;
            if (bus.rd_valid === 1'b1) begin
                seen     = 1'b1;
                got_data = bus.rd_data;
                got_to   = bus.rd_timeout;
                got_rs   = bus.RS;
                got_rw   = bus.RW;
                got_rel  = bus.bus_rel;
                got_en   = bus.EN;
            end else if (bus.RS !== rs || bus.RW !== 1'b1 || bus.bus_rel !== 1'b1 || bus.rd_ready !== 1'b0) begin
                viol++;
            end
            prev_en = bus.EN;
        end
        bus.rd_req = 1'b0;

        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_en_pulses"}, 32'(pulses), 32'(exp_reads));
        chk({tag, "_en_width"}, 32'(last_len), 32'(T_PW));
        chk({tag, "_data"}, 32'(got_data), 32'(exp_data));
        chk({tag, "_timeout"}, 32'(got_to), 32'(exp_to));
        chk({tag, "_pins_at_valid"}, {29'd0, got_rs, got_rw, got_rel}, 32'd0);
        chk({tag, "_en_at_valid"}, 32'(got_en), 32'd0);
        chk({tag, "_protocol"}, 32'(viol), 32'd0);

        @(negedge clk);
        chk({tag, "_valid_pulse"}, {30'd0, bus.rd_valid, bus.rd_timeout}, 32'd0);
        chk({tag, "_ready_after"}, 32'(bus.rd_ready), 32'd1);
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.EN || bus.RW || bus.bus_rel || bus.rd_valid) viol++;
        end
        chk({tag, "_quiet_after"}, 32'(viol), 32'd0);
        chk({tag, "_data_held"}, 32'(bus.rd_data), 32'(exp_data));
    endtask

    initial begin
        int hi, w, nbusy, bad;
        logic rs, poll;
        n_checks = 0;
        n_fail   = 0;
        bus.rd_req  = 1'b0;
        bus.rd_rs   = 1'b0;
        bus.rd_poll = 1'b0;
        bus.lcd_din = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.rd_ready), 32'd1);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        chk("rst_pins", {29'd0, bus.RS, bus.RW, bus.EN}, 32'd0);
        chk("rst_flags", {29'd0, bus.bus_rel, bus.rd_valid, bus.rd_timeout}, 32'd0);
        rst_n = 1'b1;

        data_q = '{8'h05};
        run_read("bf_read", 1'b0, 1'b0, 1'b0);
        data_q = '{8'h48};
        run_read("ram_read", 1'b1, 1'b0, 1'b0);
        data_q = '{8'hA7};
        run_read("busy_req", 1'b0, 1'b0, 1'b1);
        data_q = '{8'h80};
        run_read("poll_rs1", 1'b1, 1'b1, 1'b0);
        data_q = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
        run_read("poll_3busy", 1'b0, 1'b1, 1'b0);
        data_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run_read("poll_tmo", 1'b0, 1'b1, 1'b0);

        for (int t = 0; t < 16; t++) begin
            rs    = 1'($urandom_range(0, 1));
            poll  = 1'($urandom_range(0, 1));
            nbusy = $urandom_range(0, 5);
            data_q.delete();
            for (int i = 0; i < 7; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                b[7] = (i < nbusy);
                data_q.push_back(b);
            end
            run_read($sformatf("rnd%0d", t), rs, poll, t[0]);
        end

        // Reset in the middle of the EN-high phase.
        @(negedge clk);
        bus.rd_rs   = 1'b0;
        bus.rd_poll = 1'b0;
        bus.lcd_din = 8'h3C;
        bus.rd_req  = 1'b1;
        @(posedge clk);
        #1 bus.rd_req = 1'b0;
        hi = 0;
        w  = 0;
        while (hi < 10 && w < 100) begin
            @(negedge clk);
            w++;
            if (bus.EN) hi++;
        end
        chk("mid_rst_reach", 32'(hi), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pins", {28'd0, bus.EN, bus.RW, bus.bus_rel, bus.RS}, 32'd0);
        chk("mid_rst_ready", 32'(bus.rd_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rd_valid || bus.EN) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rd_valid || bus.EN || bus.RW) bad++;
        end
        chk("mid_rst_no_valid", 32'(bad), 32'd0);
        chk("mid_rst_data", 32'(bus.rd_data), 32'd0);

        data_q = '{8'h5A};
        run_read("post_rst", 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
